// File: rtl/psw_pkg.sv
// Shared definitions for the XM23 Program Status Word: bit positions, field
// ranges, reset/write masks and a packed view used by decode and execute.
package psw_pkg;

  localparam int PSW_C   = 0;
  localparam int PSW_Z   = 1;
  localparam int PSW_N   = 2;
  localparam int PSW_SLP = 3;
  localparam int PSW_V   = 4;

  localparam int CUR_LO = 5;
  localparam int CUR_HI = 7;
  localparam int PRV_LO = 13;
  localparam int PRV_HI = 15;

  localparam logic [15:0] PSW_RESET     = 16'h00E0;
  localparam logic [15:0] PSW_WMASK     = 16'hE0FF;
  localparam logic [15:0] PSW_FLAG_MASK = 16'h001F;

  typedef struct packed {
    logic [2:0] prv_pri;
    logic [4:0] rsvd;
    logic [2:0] cur_pri;
    logic       v;
    logic       slp;
    logic       n;
    logic       z;
    logic       c;
  } psw_t;

  // PSW after taking an exception: previous CUR moves to PRV, flags and SLP cleared.
  function automatic logic [15:0] enter_psw(input logic [15:0] prev, input logic [2:0] pri);
    psw_t r;
    r         = '0;
    r.prv_pri = prev[CUR_HI:CUR_LO];
    r.cur_pri = pri;
    return r;
  endfunction

  // SETCC/CLRCC operand {V,SLP,N,Z,C} lines up with PSW bits 4:0.
  function automatic logic [15:0] cc_to_psw(input logic [4:0] bits);
    return {11'b0, bits};
  endfunction

endpackage

// File: rtl/psw_stack.sv
// LIFO of saved PSWs for nested exceptions. Reset empties the stack;
// entries are never cleared, only overwritten by later pushes.
module psw_stack
  import psw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [15:0]               din,
  output logic [15:0]               dout,
  output logic [$clog2(DEPTH):0]    depth,
  output logic                      full,
  output logic                      empty
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   mem [DEPTH];
  logic [DW-1:0] cnt;

  assign full  = (cnt == DW'(DEPTH));
  assign empty = (cnt == '0);
  assign depth = cnt;
  assign dout  = empty ? '0 : mem[AW'(cnt - 1'b1)];

  // NOTE: storage has no reset; depth alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[AW'(cnt)] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push && !full) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/psw_reg.sv
// Architectural PSW register: merges ALU flag updates, SETCC/CLRCC, explicit
// writes and exception entry/return into one registered PSW with a saved-PSW stack.
module psw_reg
  import psw_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          alu_upd,
  input  logic [15:0]                   psw_in,
  input  logic [15:0]                   psw_msk,
  input  logic                          cc_set,
  input  logic                          cc_clr,
  input  logic [4:0]                    cc_bits,
  input  logic                          wr_en,
  input  logic [15:0]                   wr_data,
  input  logic                          exc_entry,
  input  logic [2:0]                    exc_pri,
  input  logic                          exc_ret,
  output logic [15:0]                   psw,
  output logic [$clog2(STACK_DEPTH):0]  depth,
  output logic                          fault
);

  logic [15:0] psw_q;
  logic [15:0] psw_d;
  logic [15:0] psw_next;
  logic [15:0] stk_top;
  logic [15:0] flag_msk;
  logic [15:0] cc_vec;
  logic        stk_full;
  logic        stk_empty;
  logic        push;
  logic        pop;
  logic        fault_set;
  logic        fault_q;

  assign flag_msk = psw_msk & PSW_FLAG_MASK;
  assign cc_vec   = cc_to_psw(cc_bits);

  // NOTE: every variable gets a default before any branch so no path infers a latch.
  always_comb begin
    psw_d     = psw_q;
    psw_next  = psw_q;
    push      = 1'b0;
    pop       = 1'b0;
    fault_set = 1'b0;

    if (alu_upd) psw_d = (psw_d & ~flag_msk) | (psw_in & flag_msk);
    if (cc_clr)  psw_d = psw_d & ~cc_vec;
    if (cc_set)  psw_d = psw_d | cc_vec;
    if (wr_en)   psw_d = wr_data & PSW_WMASK;

    psw_next = psw_d;

    // Entry outranks return; psw_d is what gets saved so same-cycle updates survive.
    if (exc_entry) begin
      if (!stk_full) begin
        push     = 1'b1;
        psw_next = enter_psw(psw_d, exc_pri);
      end else begin
        fault_set = 1'b1;
      end
    end else if (exc_ret) begin
      if (!stk_empty) begin
        pop      = 1'b1;
        psw_next = stk_top & PSW_WMASK;
      end else begin
        fault_set = 1'b1;
      end
    end
  end

  psw_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !stall),
    .pop   (pop && !stall),
    .din   (psw_d),
    .dout  (stk_top),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      psw_q   <= PSW_RESET;
      fault_q <= 1'b0;
    end else if (!stall) begin
      psw_q   <= psw_next;
      fault_q <= fault_q | fault_set;
    end
  end

  assign psw   = psw_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_psw_reg.sv
// Self-checking bench for psw_reg: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based PSW model.
module tb_psw_reg;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        alu_upd;
  logic [15:0] psw_in;
  logic [15:0] psw_msk;
  logic        cc_set;
  logic        cc_clr;
  logic [4:0]  cc_bits;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        exc_entry;
  logic [2:0]  exc_pri;
  logic        exc_ret;
  logic [15:0] psw;
  logic [2:0]  depth;
  logic        fault;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [15:0] m_psw;
  logic [15:0] m_saved[$];
  logic        m_fault;

  psw_reg #(.STACK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .alu_upd   (alu_upd),
    .psw_in    (psw_in),
    .psw_msk   (psw_msk),
    .cc_set    (cc_set),
    .cc_clr    (cc_clr),
    .cc_bits   (cc_bits),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .exc_entry (exc_entry),
    .exc_pri   (exc_pri),
    .exc_ret   (exc_ret),
    .psw       (psw),
    .depth     (depth),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the architectural rules, applied in order of precedence.
  task automatic model_step();
    logic [15:0] p;
    if (rst) begin
      m_psw   = 16'h00E0;
      m_fault = 1'b0;
      m_saved.delete();
    end else if (!stall) begin
      p = m_psw;
      if (alu_upd) p = (p & ~(psw_msk & 16'h001F)) | (psw_in & psw_msk & 16'h001F);
      if (cc_clr)  p = p & ~{11'b0, cc_bits};
      if (cc_set)  p = p | {11'b0, cc_bits};
      if (wr_en)   p = wr_data & 16'hE0FF;
      if (exc_entry) begin
        if (m_saved.size() < DEPTH) begin
          m_saved.push_back(p);
          p = {p[7:5], 5'b0, exc_pri, 5'b0};
        end else begin
          m_fault = 1'b1;
        end
      end else if (exc_ret) begin
        if (m_saved.size() > 0) p = m_saved.pop_back();
        else                    m_fault = 1'b1;
      end
      m_psw = p;
    end
  endtask

  task automatic idle();
    rst = 1'b0; stall = 1'b0; alu_upd = 1'b0; psw_in = '0; psw_msk = '0;
    cc_set = 1'b0; cc_clr = 1'b0; cc_bits = '0; wr_en = 1'b0; wr_data = '0;
    exc_entry = 1'b0; exc_pri = '0; exc_ret = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("psw", 32'(psw), 32'(m_psw));
      check("depth", 32'(depth), 32'(m_saved.size()));
      check("fault", 32'(fault), 32'(m_fault));
    end
  end

  initial begin
    idle();
    m_psw   = 16'h0000;
    m_fault = 1'b0;

    // Reset, then reset held with stall and other requests active
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    check("rst_psw", 32'(psw), 32'h00E0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    stall = 1'b1; alu_upd = 1'b1; psw_in = 16'hFFFF; psw_msk = 16'hFFFF; exc_entry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_stall_psw", 32'(psw), 32'h00E0);
      check("rst_stall_depth", 32'(depth), 32'd0);
    end

    // Masked ALU updates
    idle();
    alu_upd = 1'b1; psw_in = 16'h0013; psw_msk = 16'h0017;
    tick();
    check("alu_mask1", 32'(psw), 32'h00F3);
    psw_in = 16'h0000; psw_msk = 16'h0002;
    tick();
    check("alu_mask2", 32'(psw), 32'h00F1);

    // SETCC+CLRCC together over an ALU update, then full write
    idle();
    alu_upd = 1'b1; psw_in = 16'h0002; psw_msk = 16'h0002;
    cc_set = 1'b1; cc_clr = 1'b1; cc_bits = 5'b00101;
    tick();
    check("cc_both", 32'(psw), 32'h00F7);
    idle();
    wr_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    check("wr_mask", 32'(psw), 32'hE0FF);

    // Entry with same-cycle V update, then return
    idle();
    wr_en = 1'b1; wr_data = 16'h00E5;
    tick();
    idle();
    exc_entry = 1'b1; exc_pri = 3'd3; alu_upd = 1'b1; psw_in = 16'h0010; psw_msk = 16'h0010;
    tick();
    check("entry_psw", 32'(psw), 32'hE060);
    check("entry_depth", 32'(depth), 32'd1);
    idle();
    exc_ret = 1'b1;
    tick();
    check("ret_psw", 32'(psw), 32'h00F5);
    check("ret_depth", 32'(depth), 32'd0);

    // Overflow on 5th entry, LIFO restores, underflow on 5th return
    idle();
    rst = 1'b1;
    tick();
    idle();
    for (int i = 1; i <= 5; i++) begin
      exc_entry = 1'b1; exc_pri = 3'(i);
      tick();
    end
    check("ovf_psw", 32'(psw), 32'h6080);
    check("ovf_depth", 32'(depth), 32'd4);
    check("ovf_fault", 32'(fault), 32'd1);
    idle();
    exc_ret = 1'b1;
    tick(); check("pop1", 32'(psw), 32'h4060);
    tick(); check("pop2", 32'(psw), 32'h2040);
    tick(); check("pop3", 32'(psw), 32'hE020);
    tick(); check("pop4", 32'(psw), 32'h00E0);
    tick();
    check("unf_psw", 32'(psw), 32'h00E0);
    check("unf_fault", 32'(fault), 32'd1);
    idle();
    tick();
    check("fault_sticky", 32'(fault), 32'd1);
    rst = 1'b1;
    tick();
    check("fault_clr", 32'(fault), 32'd0);

    // Stall freezes everything; entry beats return in the same cycle
    idle();
    wr_en = 1'b1; wr_data = 16'h00E3;
    tick();
    idle();
    stall = 1'b1; alu_upd = 1'b1; psw_in = 16'hFFFF; psw_msk = 16'hFFFF; exc_entry = 1'b1;
    tick();
    check("stall_psw", 32'(psw), 32'h00E3);
    check("stall_depth", 32'(depth), 32'd0);
    idle();
    exc_entry = 1'b1; exc_ret = 1'b1; exc_pri = 3'd2;
    tick();
    check("entry_ret_depth", 32'(depth), 32'd1);
    check("entry_ret_psw", 32'(psw), 32'hE040);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) < 1);
      stall     = ($urandom_range(99) < 10);
      alu_upd   = ($urandom_range(99) < 50);
      psw_in    = 16'($urandom);
      psw_msk   = 16'($urandom);
      cc_set    = ($urandom_range(99) < 20);
      cc_clr    = ($urandom_range(99) < 20);
      cc_bits   = 5'($urandom);
      wr_en     = ($urandom_range(99) < 10);
      wr_data   = 16'($urandom);
      exc_entry = ($urandom_range(99) < 18);
      exc_pri   = 3'($urandom);
      exc_ret   = ($urandom_range(99) < 18);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
